// File: rtl/dbus_responder.sv
// Data-bus responder: accepts one request at a time, waits LATENCY cycles,
// then issues a single-cycle response against a byte-writable 64-bit word store.
module dbus_responder #(
  parameter int MEM_WORDS = 1024,
  parameter int LATENCY   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [63:0] req_addr,
  input  logic [2:0]  req_size,
  input  logic [7:0]  req_strobe,
  input  logic [63:0] req_data,
  output logic        resp_addr_ok,
  output logic        resp_data_ok,
  output logic [63:0] resp_data,
  output logic [31:0] txn_count
);

  localparam int         IDX_W   = $clog2(MEM_WORDS);
  localparam logic [3:0] LAT_C   = 4'(LATENCY);
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]       state_r;
  logic [1:0]       state_nxt_s;
  logic [3:0]       wait_cnt_r;
  logic [3:0]       wait_cnt_nxt_s;
  logic             accept_s;
  logic [IDX_W-1:0] req_idx_s;
  logic [IDX_W-1:0] rd_idx_s;
  logic             rd_is_read_s;
  logic [IDX_W-1:0] idx_r;
  logic [7:0]       strobe_r;
  logic [63:0]      wdata_r;
  logic [2:0]       size_r;
  logic             resp_ok_r;
  logic [63:0]      resp_data_r;
  logic [31:0]      txn_count_r;
  logic             unused_s;
  logic [63:0]      mem_r [MEM_WORDS];

  assign req_idx_s = req_addr[3 +: IDX_W];

  // Size code is only captured; low byte-offset and high wrap bits never select storage.
  assign unused_s = ^{size_r, req_addr[63:3+IDX_W], req_addr[2:0]};

  // Next-state and wait-counter logic.
  always_comb begin
    state_nxt_s    = state_r;
    wait_cnt_nxt_s = wait_cnt_r;
    accept_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (req_valid) begin
          accept_s       = 1'b1;
          wait_cnt_nxt_s = LAT_C;
          state_nxt_s    = (LAT_C == 4'd0) ? ST_RESP : ST_WAIT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (wait_cnt_r <= 4'd1) begin
          state_nxt_s    = ST_RESP;
          wait_cnt_nxt_s = 4'd0;
        end else begin
          wait_cnt_nxt_s = wait_cnt_r - 4'd1;
        end
      end
      ST_RESP: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s    = ST_IDLE;
        wait_cnt_nxt_s = 4'd0;
      end
    endcase
    // With zero latency the response is loaded on the accept edge, before fields are latched.
    if (accept_s) begin
      rd_idx_s     = req_idx_s;
      rd_is_read_s = (req_strobe == 8'd0);
    end else begin
      rd_idx_s     = idx_r;
      rd_is_read_s = (strobe_r == 8'd0);
    end
  end

  // Control state, latched request and registered response outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      wait_cnt_r  <= 4'd0;
      idx_r       <= '0;
      strobe_r    <= 8'd0;
      wdata_r     <= 64'd0;
      size_r      <= 3'd0;
      resp_ok_r   <= 1'b0;
      resp_data_r <= 64'd0;
      txn_count_r <= 32'd0;
    end else begin
      state_r    <= state_nxt_s;
      wait_cnt_r <= wait_cnt_nxt_s;
      resp_ok_r  <= (state_nxt_s == ST_RESP);
      if ((state_nxt_s == ST_RESP) && rd_is_read_s) begin
        resp_data_r <= mem_r[rd_idx_s];
      end else begin
        resp_data_r <= 64'd0;
      end
      if (state_r == ST_RESP) begin
        txn_count_r <= txn_count_r + 32'd1;
      end
      if (accept_s) begin
        idx_r    <= req_idx_s;
        strobe_r <= req_strobe;
        wdata_r  <= req_data;
        size_r   <= req_size;
      end
    end
  end

  // Byte-masked write commit at the end of the response cycle; storage survives reset.
  always_ff @(posedge clk) begin
    if (!reset && (state_r == ST_RESP)) begin
      for (int b = 0; b < 8; b++) begin
        if (strobe_r[b]) begin
          mem_r[idx_r][b*8 +: 8] <= wdata_r[b*8 +: 8];
        end
      end
    end
  end

  assign resp_addr_ok = resp_ok_r;
  assign resp_data_ok = resp_ok_r;
  assign resp_data    = resp_data_r;
  assign txn_count    = txn_count_r;

endmodule

// File: tb/tb_dbus_responder.sv
// Directed self-checking bench for dbus_responder: a LATENCY=2 instance for the
// main scenarios and a LATENCY=0 instance for back-to-back timing.
module tb_dbus_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [63:0] req_addr;
  logic [2:0]  req_size;
  logic [7:0]  req_strobe;
  logic [63:0] req_data;
  logic        resp_addr_ok;
  logic        resp_data_ok;
  logic [63:0] resp_data;
  logic [31:0] txn_count;

  logic        req_valid0;
  logic [63:0] req_addr0;
  logic [2:0]  req_size0;
  logic [7:0]  req_strobe0;
  logic [63:0] req_data0;
  logic        resp_addr_ok0;
  logic        resp_data_ok0;
  logic [63:0] resp_data0;
  logic [31:0] txn_count0;

  int n_tests = 0;
  int n_fail  = 0;
  bit quiet_bad = 1'b0;

  always #5 clk = ~clk;

  dbus_responder #(.MEM_WORDS(1024), .LATENCY(2)) u_dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
    .req_size(req_size), .req_strobe(req_strobe), .req_data(req_data),
    .resp_addr_ok(resp_addr_ok), .resp_data_ok(resp_data_ok),
    .resp_data(resp_data), .txn_count(txn_count)
  );

  dbus_responder #(.MEM_WORDS(1024), .LATENCY(0)) u_dut0 (
    .clk(clk), .reset(reset), .req_valid(req_valid0), .req_addr(req_addr0),
    .req_size(req_size0), .req_strobe(req_strobe0), .req_data(req_data0),
    .resp_addr_ok(resp_addr_ok0), .resp_data_ok(resp_data_ok0),
    .resp_data(resp_data0), .txn_count(txn_count0)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One transaction on the LATENCY=2 instance; lat is the cycle of the response pulse
  // counted from the accept cycle (cycle 0), or -1 if none arrives.
  task automatic txn(input logic [63:0] addr, input logic [7:0] strb, input logic [63:0] data,
                     input bit perturb, output logic [63:0] rdata, output int lat);
    req_valid  = 1'b1;
    req_addr   = addr;
    req_strobe = strb;
    req_data   = data;
    req_size   = 3'd3;
    lat   = -1;
    rdata = 64'd0;
    for (int k = 1; k <= 40 && lat < 0; k++) begin
      tick;
      if (k == 1) begin
        req_valid = 1'b0;
        if (perturb) begin
          req_data   = ~data;
          req_addr   = addr + 64'h8;
          req_strobe = 8'h0F;
        end
      end
      if (resp_data_ok) begin
        lat   = k;
        rdata = resp_data;
        if (!resp_addr_ok) quiet_bad = 1'b1;
      end else if (resp_addr_ok || (resp_data != 64'd0)) begin
        quiet_bad = 1'b1;
      end
    end
    tick;
  endtask

  logic [63:0] rd;
  int          lat;

  initial begin
    reset = 1'b1;
    req_valid = 1'b0; req_addr = 64'd0; req_size = 3'd0; req_strobe = 8'd0; req_data = 64'd0;
    req_valid0 = 1'b0; req_addr0 = 64'd0; req_size0 = 3'd0; req_strobe0 = 8'd0; req_data0 = 64'd0;
    tick;
    tick;
    check("rst_addr_ok", 64'(resp_addr_ok), 64'd0);
    check("rst_data_ok", 64'(resp_data_ok), 64'd0);
    check("rst_data", resp_data, 64'd0);
    check("rst_count", 64'(txn_count), 64'd0);
    reset = 1'b0;
    tick;

    // Zero latency, valid held for two requests: pulses in cycles 1 and 3.
    req_valid0 = 1'b1; req_addr0 = 64'h40; req_strobe0 = 8'hFF; req_data0 = 64'h0102030405060708;
    check("l0_c0", 64'(resp_data_ok0), 64'd0);
    tick;
    check("l0_c1", 64'(resp_data_ok0), 64'd1);
    tick;
    check("l0_c2", 64'(resp_data_ok0), 64'd0);
    tick;
    check("l0_c3", 64'(resp_data_ok0), 64'd1);
    req_valid0 = 1'b0;
    tick;
    check("l0_c4", 64'(resp_data_ok0), 64'd0);
    check("l0_count", 64'(txn_count0), 64'd2);

    // Full write then read of 0x10.
    txn(64'h10, 8'hFF, 64'h1122334455667788, 1'b0, rd, lat);
    check("wr_lat", 64'(lat), 64'd3);
    check("wr_data_zero", rd, 64'd0);
    txn(64'h10, 8'h00, 64'd0, 1'b0, rd, lat);
    check("rd_lat", 64'(lat), 64'd3);
    check("rd_data", rd, 64'h1122334455667788);
    check("count2", 64'(txn_count), 64'd2);

    // Partial write of the low four bytes.
    txn(64'h10, 8'h0F, 64'hAAAAAAAA_BBBBBBBB, 1'b0, rd, lat);
    txn(64'h10, 8'h00, 64'd0, 1'b0, rd, lat);
    check("partial", rd, 64'h11223344_BBBBBBBB);

    // Address wrap and ignored byte offset.
    txn(64'h2000, 8'hFF, 64'hDEADBEEF_CAFEF00D, 1'b0, rd, lat);
    txn(64'h0, 8'h00, 64'd0, 1'b0, rd, lat);
    check("wrap", rd, 64'hDEADBEEF_CAFEF00D);
    txn(64'h7, 8'h00, 64'd0, 1'b0, rd, lat);
    check("offset", rd, 64'hDEADBEEF_CAFEF00D);
    check("count7", 64'(txn_count), 64'd7);

    // Inputs dropped and scrambled during WAIT.
    txn(64'h20, 8'hFF, 64'h01234567_89ABCDEF, 1'b1, rd, lat);
    check("perturb_lat", 64'(lat), 64'd3);
    txn(64'h20, 8'h00, 64'd0, 1'b0, rd, lat);
    check("perturb_data", rd, 64'h01234567_89ABCDEF);

    // Reset landing on the response cycle of a write to 0x18.
    txn(64'h18, 8'hFF, 64'h5555AAAA_5555AAAA, 1'b0, rd, lat);
    req_valid = 1'b1; req_addr = 64'h18; req_strobe = 8'hFF; req_data = 64'h99999999_99999999;
    lat = -1;
    for (int k = 1; k <= 40 && lat < 0; k++) begin
      tick;
      req_valid = 1'b0;
      if (resp_data_ok) lat = k;
    end
    check("abort_lat", 64'(lat), 64'd3);
    reset = 1'b1;
    tick;
    check("abort_addr_ok", 64'(resp_addr_ok), 64'd0);
    check("abort_data_ok", 64'(resp_data_ok), 64'd0);
    check("abort_data", resp_data, 64'd0);
    check("abort_count", 64'(txn_count), 64'd0);
    reset = 1'b0;
    tick;
    txn(64'h18, 8'h00, 64'd0, 1'b0, rd, lat);
    check("abort_keep", rd, 64'h5555AAAA_5555AAAA);
    txn(64'h10, 8'h00, 64'd0, 1'b0, rd, lat);
    check("mem_survives", rd, 64'h11223344_BBBBBBBB);
    check("count_after", 64'(txn_count), 64'd2);

    check("quiet_outputs", 64'(quiet_bad), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
